goomba_contact_ctrl: RTL and testbench

//  Downstream consumer of the goomba walker's screen-space position/enable outputs.

---
 rtl/goomba_contact_ctrl_if.sv | 30 +++
 rtl/goomba_contact_ctrl.sv | 162 ++++++++++++++++
 tb/tb_goomba_contact_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/goomba_contact_ctrl_if.sv
// Goomba contact interface: bundles the character/goomba geometry coming in and the
// contact/lives status going out to the renderer and game controller.
//   master : drives char_X/char_Y/char_falling/enemy_x/enemy_y/enemy_en, reads status
//   slave  : the contact controller (reads geometry, drives status)
interface goomba_contact_ctrl_if;
  logic [9:0] char_X;
  logic [9:0] char_Y;
  logic       char_falling;
  logic [9:0] enemy_x;
  logic [9:0] enemy_y;
  logic       enemy_en;
  logic       enemy_vis;
  logic       squish;
  logic       bounce;
  logic       score_inc;
  logic       player_hit;
  logic       invuln;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output char_X, char_Y, char_falling, enemy_x, enemy_y, enemy_en,
    input  enemy_vis, squish, bounce, score_inc, player_hit, invuln, lives, game_over
  );

  modport slave (
    input  char_X, char_Y, char_falling, enemy_x, enemy_y, enemy_en,
    output enemy_vis, squish, bounce, score_inc, player_hit, invuln, lives, game_over
  );
endinterface

// File: rtl/goomba_contact_ctrl.sv
// Goomba contact controller: resolves goomba-vs-character contact every sys_clk as
// either a stomp (goomba squished, character bounces, score) or a side hit (life lost,
// invulnerability window). Owns the goomba life FSM, the lives counter and game-over.
// Ports:
//   sys_clk  system clock
//   RST_N    asynchronous active-low reset
//   bus      goomba_contact_ctrl_if.slave (geometry in, contact/status out)
// Optional feature: define GOOMBA_RESPAWN_EN to let a GONE goomba respawn after
// RESPAWN_TICKS game ticks (held off while the character overlaps the spawn point).
module goomba_contact_ctrl #(
  parameter int unsigned BOX_W        = 12,
  parameter int unsigned STOMP_MARGIN = 4,
  parameter int unsigned TICK_DIV     = 2_500_000,
  parameter int unsigned SQUISH_TICKS = 8,
  parameter int unsigned INVULN_TICKS = 20,
  parameter int unsigned LIVES_INIT   = 3
`ifdef GOOMBA_RESPAWN_EN
  ,
  parameter int unsigned RESPAWN_TICKS = 50
`endif
) (
  input logic                  sys_clk,
  input logic                  RST_N,
  goomba_contact_ctrl_if.slave bus
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef GOOMBA_RESPAWN_EN
  localparam int unsigned TmrMax = (SQUISH_TICKS > RESPAWN_TICKS) ? SQUISH_TICKS : RESPAWN_TICKS;
`else
  localparam int unsigned TmrMax = SQUISH_TICKS;
`endif
  localparam int unsigned TmrW = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam int unsigned InvW = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;

  typedef enum logic [1:0] {StAlive, StSquish, StGone} enemy_st_e;

  enemy_st_e       r_state, w_state_nxt;
  logic [TmrW-1:0] r_etmr, w_etmr_nxt;
  logic [InvW-1:0] r_itmr, w_itmr_nxt;
  logic [DivW-1:0] r_div, w_div_nxt;
  logic            r_invuln, w_invuln_nxt;
  logic [1:0]      r_lives, w_lives_nxt;
  logic            r_game_over, w_game_over_nxt;
  logic            r_bounce, r_hit;

  logic            w_tick;
  logic [10:0]     w_dx_s, w_dy_s, w_dx, w_dy;
  logic            w_geom, w_overlap, w_stomp, w_side;

  assign w_tick    = (r_div == DivW'(TICK_DIV - 1));
  assign w_div_nxt = w_tick ? '0 : r_div + DivW'(1);

  // 11-bit differences so neither axis wraps at the 0/1023 screen edges.
  assign w_dx_s = {1'b0, bus.char_X} - {1'b0, bus.enemy_x};
  assign w_dy_s = {1'b0, bus.char_Y} - {1'b0, bus.enemy_y};
  assign w_dx   = w_dx_s[10] ? (~w_dx_s + 11'd1) : w_dx_s;
  assign w_dy   = w_dy_s[10] ? (~w_dy_s + 11'd1) : w_dy_s;

  assign w_geom    = (w_dx < 11'(BOX_W)) && (w_dy < 11'(BOX_W));
  assign w_overlap = bus.enemy_en && (r_state == StAlive) && w_geom;
  // y grows downward: the character must sit at least STOMP_MARGIN above the goomba.
  assign w_stomp   = w_overlap && bus.char_falling && !r_game_over &&
                     (({1'b0, bus.char_Y} + 11'(STOMP_MARGIN)) <= {1'b0, bus.enemy_y});
  assign w_side    = w_overlap && !w_stomp && !r_invuln && !r_game_over;

  always_comb begin
    w_state_nxt     = r_state;
    w_etmr_nxt      = r_etmr;
    w_itmr_nxt      = r_itmr;
    w_invuln_nxt    = r_invuln;
    w_lives_nxt     = r_lives;
    w_game_over_nxt = r_game_over;

    // Goomba disabled in the level: everything frozen where it is.
    if (bus.enemy_en) begin
      case (r_state)
        StAlive: begin
          if (w_stomp) begin
            w_state_nxt = StSquish;
            w_etmr_nxt  = '0;
          end
        end
        StSquish: begin
          if (w_tick) begin
            if (r_etmr == TmrW'(SQUISH_TICKS - 1)) begin
              w_state_nxt = StGone;
              w_etmr_nxt  = '0;
            end else begin
              w_etmr_nxt = r_etmr + TmrW'(1);
            end
          end
        end
        StGone: begin
`ifdef GOOMBA_RESPAWN_EN
          // Count saturates at the last tick; respawn only once the spawn point is clear.
          if (w_tick) begin
            if (r_etmr != TmrW'(RESPAWN_TICKS - 1)) begin
              w_etmr_nxt = r_etmr + TmrW'(1);
            end else if (!w_geom) begin
              w_state_nxt = StAlive;
              w_etmr_nxt  = '0;
            end
          end
`endif
        end
        default: w_state_nxt = StAlive;
      endcase
    end

    if (w_side) begin
      w_invuln_nxt = 1'b1;
      w_itmr_nxt   = '0;
      if (r_lives != 2'd0) begin
        w_lives_nxt = r_lives - 2'd1;
      end
      if (r_lives == 2'd1) begin
        w_game_over_nxt = 1'b1;
      end
    end else if (r_invuln && w_tick) begin
      if (r_itmr == InvW'(INVULN_TICKS - 1)) begin
        w_invuln_nxt = 1'b0;
      end else begin
        w_itmr_nxt = r_itmr + InvW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= StAlive;
      r_etmr      <= '0;
      r_itmr      <= '0;
      r_div       <= '0;
      r_invuln    <= 1'b0;
      r_lives     <= 2'(LIVES_INIT);
      r_game_over <= 1'b0;
      r_bounce    <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_etmr      <= w_etmr_nxt;
      r_itmr      <= w_itmr_nxt;
      r_div       <= w_div_nxt;
      r_invuln    <= w_invuln_nxt;
      r_lives     <= w_lives_nxt;
      r_game_over <= w_game_over_nxt;
      r_bounce    <= w_stomp;
      r_hit       <= w_side;
    end
  end

  assign bus.enemy_vis  = bus.enemy_en && (r_state != StGone);
  assign bus.squish     = (r_state == StSquish);
  assign bus.bounce     = r_bounce;
  assign bus.score_inc  = r_bounce;
  assign bus.player_hit = r_hit;
  assign bus.invuln     = r_invuln;
  assign bus.lives      = r_lives;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_goomba_contact_ctrl.sv
// Directed testbench for goomba_contact_ctrl (TICK_DIV=4). Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that updates them.
module tb_goomba_contact_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  goomba_contact_ctrl_if u_if ();

  goomba_contact_ctrl #(
    .TICK_DIV(4)
  ) u_dut (
    .sys_clk(clk),
    .RST_N  (rst_n),
    .bus    (u_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_pos(input int cx, input int cy, input bit fall, input int ex, input int ey,
                         input bit en);
    u_if.char_X       = 10'(cx);
    u_if.char_Y       = 10'(cy);
    u_if.char_falling = fall;
    u_if.enemy_x      = 10'(ex);
    u_if.enemy_y      = 10'(ey);
    u_if.enemy_en     = en;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts on the falling edge just after a hit edge; returns edges until the next hit,
  // invuln one edge before that hit, and invuln 76 edges in (19 ticks at most).
  task automatic wait_hit(output int k, output bit prev_inv, output bit inv76);
    bit last_inv;
    k        = 0;
    prev_inv = 1'b1;
    inv76    = 1'b0;
    last_inv = u_if.invuln;
    while (k < 120) begin
      step(1);
      k++;
      if (k == 76) inv76 = u_if.invuln;
      if (u_if.player_hit) begin
        prev_inv = last_inv;
        break;
      end
      last_inv = u_if.invuln;
    end
  endtask

  task automatic wait_gone(output int k);
    k = 0;
    while (k < 40 && u_if.enemy_vis) begin
      step(1);
      k++;
    end
  endtask

  int k;
  int pulses;
  bit prev_inv, inv76;

  initial begin
    rst_n = 1'b0;
    set_pos(300, 100, 0, 100, 370, 1);
    #12;
    check_eq("rst_vis", u_if.enemy_vis, 1);
    check_eq("rst_squish", u_if.squish, 0);
    check_eq("rst_bounce", u_if.bounce, 0);
    check_eq("rst_hit", u_if.player_hit, 0);
    check_eq("rst_invuln", u_if.invuln, 0);
    check_eq("rst_lives", u_if.lives, 3);
    check_eq("rst_gameover", u_if.game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stomp and squish duration.
    set_pos(102, 360, 1, 100, 370, 1);
    step(1);
    check_eq("stomp_bounce", u_if.bounce, 1);
    check_eq("stomp_score", u_if.score_inc, 1);
    check_eq("stomp_squish", u_if.squish, 1);
    set_pos(300, 100, 0, 100, 370, 1);
    step(1);
    check_eq("stomp_bounce_1cyc", u_if.bounce, 0);
    check_eq("stomp_score_1cyc", u_if.score_inc, 0);
    step(27);
    check_eq("squish_7ticks", u_if.squish, 1);
    step(4);
    check_eq("squish_done", u_if.squish, 0);
    check_eq("gone_vis", u_if.enemy_vis, 0);
    set_pos(100, 370, 0, 100, 370, 1);
    step(3);
    check_eq("gone_no_hit_lives", u_if.lives, 3);

    // Side hit, stomp during invuln, then async reset mid-squish/invuln.
    do_reset();
    set_pos(100, 370, 0, 100, 370, 1);
    step(1);
    check_eq("side_hit", u_if.player_hit, 1);
    check_eq("side_lives", u_if.lives, 2);
    check_eq("side_invuln", u_if.invuln, 1);
    set_pos(100, 360, 1, 100, 370, 1);
    step(1);
    check_eq("inv_stomp_bounce", u_if.bounce, 1);
    check_eq("inv_stomp_hit", u_if.player_hit, 0);
    set_pos(300, 100, 0, 100, 370, 1);
    step(3);
    check_eq("pre_rst_squish", u_if.squish, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_squish", u_if.squish, 0);
    check_eq("arst_vis", u_if.enemy_vis, 1);
    check_eq("arst_lives", u_if.lives, 3);
    check_eq("arst_invuln", u_if.invuln, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contact window boundaries.
    set_pos(112, 370, 0, 100, 370, 1);
    step(2);
    check_eq("dx12_pos", u_if.lives, 3);
    set_pos(88, 370, 0, 100, 370, 1);
    step(2);
    check_eq("dx12_neg", u_if.lives, 3);
    set_pos(100, 382, 0, 100, 370, 1);
    step(2);
    check_eq("dy12", u_if.lives, 3);
    set_pos(1020, 370, 0, 5, 370, 1);
    step(2);
    check_eq("no_wrap", u_if.lives, 3);
    set_pos(111, 370, 0, 100, 370, 1);
    step(1);
    check_eq("dx11_hit", u_if.player_hit, 1);
    check_eq("dx11_lives", u_if.lives, 2);
    do_reset();
    set_pos(100, 366, 1, 100, 370, 1);
    step(1);
    check_eq("y366_bounce", u_if.bounce, 1);
    check_eq("y366_hit", u_if.player_hit, 0);
    do_reset();
    set_pos(100, 367, 1, 100, 370, 1);
    step(1);
    check_eq("y367_bounce", u_if.bounce, 0);
    check_eq("y367_hit", u_if.player_hit, 1);

    // Held overlap: one hit per invuln window, next hit right after expiry.
    wait_hit(k, prev_inv, inv76);
    check_eq("hit2_window", (k >= 78 && k <= 81), 1);
    check_eq("hit2_inv76", inv76, 1);
    check_eq("hit2_prev_inv", prev_inv, 0);
    check_eq("hit2_lives", u_if.lives, 1);
    wait_hit(k, prev_inv, inv76);
    check_eq("hit3_window", (k >= 78 && k <= 81), 1);
    check_eq("hit3_lives", u_if.lives, 0);
    check_eq("hit3_gameover", u_if.game_over, 1);

    // Game over: no more pulses of any kind.
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) set_pos(100, 360, 1, 100, 370, 1);
      step(1);
      if (u_if.player_hit || u_if.bounce) pulses++;
    end
    check_eq("go_pulses", pulses, 0);
    check_eq("go_lives", u_if.lives, 0);
    check_eq("go_sticky", u_if.game_over, 1);

    // Respawn behaviour.
    do_reset();
    set_pos(100, 360, 1, 100, 370, 1);
    step(1);
    set_pos(300, 100, 0, 100, 370, 1);
    wait_gone(k);
    check_eq("resp_gone_found", (k >= 29 && k <= 32), 1);
`ifdef GOOMBA_RESPAWN_EN
    step(196);
    check_eq("resp_49ticks", u_if.enemy_vis, 0);
    step(4);
    check_eq("resp_alive", u_if.enemy_vis, 1);
    set_pos(100, 360, 1, 100, 370, 1);
    step(1);
    set_pos(300, 100, 0, 100, 370, 1);
    wait_gone(k);
    check_eq("resp2_gone_found", (k >= 29 && k <= 32), 1);
    set_pos(100, 370, 0, 100, 370, 1);
    step(220);
    check_eq("resp_blocked", u_if.enemy_vis, 0);
    check_eq("resp_blocked_lives", u_if.lives, 3);
    set_pos(300, 100, 0, 100, 370, 1);
    step(4);
    check_eq("resp_after_clear", u_if.enemy_vis, 1);
`else
    step(250);
    check_eq("no_resp_vis", u_if.enemy_vis, 0);
    check_eq("no_resp_squish", u_if.squish, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
